sst_seq: RTL

- Initiator side of the save-state register bus that every mapper (VRC2/VRC4 family included) exposes as a responder through act, addr, we_reg, dato and di.
- Save: walks the register address space, reads each mapper byte and streams it out.
- Restore: takes a byte stream and writes it back into the mapper registers.
- Sits between the menu/USB save-state engine and the mapper bus mux.

---
 rtl/sst_seq_if.sv | 33 +++
 rtl/sst_seq.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/sst_seq_if.sv
// Save-state bus plus save/restore byte streams.
// master: sequencer side; slave: mapper mux / stream endpoints.
interface sst_seq_if;
    logic       sst_act;
    logic [7:0] sst_addr;
    logic       sst_we_reg;
    logic [7:0] sst_dato;
    logic [7:0] sst_di;
    logic       s_valid;
    logic       s_ready;
    logic [7:0] s_data;
    logic       m_valid;
    logic       m_ready;
    logic [7:0] m_data;

    modport master (
        output sst_act, sst_addr, sst_we_reg, sst_dato,
        input  sst_di,
        input  s_valid, s_data,
        output s_ready,
        output m_valid, m_data,
        input  m_ready
    );

    modport slave (
        input  sst_act, sst_addr, sst_we_reg, sst_dato,
        output sst_di,
        output s_valid, s_data,
        input  s_ready,
        input  m_valid, m_data,
        output m_ready
    );
endinterface

// File: rtl/sst_seq.sv
// Save-state initiator: walks mapper registers 0..REGS-1, streaming
// them out (save) or writing a byte stream back into them (restore).
// Ports: clk, rst (async, active-high); start/dir/abort command;
// map_idx for the restore index check; bus (sst_seq_if.master)
// carrying the register bus and both streams; busy/done/err status.
// Macro SST_SEQ_CRC_EN appends a CRC-8 (poly 0x07) byte to each stream.
module sst_seq #(
    parameter int REGS     = 128,
    parameter int RD_LAT   = 2,
    parameter int IDX_ADDR = 127
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       dir,
    input  logic       abort,
    input  logic [7:0] map_idx,
    sst_seq_if.master  bus,
    output logic       busy,
    output logic       done,
    output logic       err
);

    localparam logic [7:0] LAST = 8'(REGS - 1);
    localparam logic [7:0] IDX  = 8'(IDX_ADDR);
    localparam logic [2:0] W0   = 3'(RD_LAT - 1);

    typedef enum logic [3:0] {
        IDLE, S_ADDR, S_WAIT, S_OUT, R_IN, R_WR, FIN
`ifdef SST_SEQ_CRC_EN
        , S_CRC, R_CRC
`endif
    } state_t;

`ifdef SST_SEQ_CRC_EN
    localparam state_t S_LAST = S_CRC;
    localparam state_t R_LAST = R_CRC;

    function automatic logic [7:0] crc8(input logic [7:0] c,
                                        input logic [7:0] d);
        logic [7:0] r;
        r = c ^ d;
        for (int i = 0; i < 8; i++)
            r = r[7] ? ((r << 1) ^ 8'h07) : (r << 1);
        return r;
    endfunction

    logic [7:0] crc_q, crc_d;
`else
    localparam state_t S_LAST = FIN;
    localparam state_t R_LAST = FIN;
`endif

    state_t     state_q, state_n;
    logic [7:0] cnt_q, cnt_d;
    logic [2:0] w_q, w_d;
    logic       act_q, act_d;
    logic [7:0] addr_q, addr_d;
    logic       we_q, we_d;
    logic [7:0] dato_q, dato_d;
    logic       mvalid_q, mvalid_d;
    logic [7:0] mdata_q, mdata_d;
    logic       sready_q, sready_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;
    logic       err_q, err_d;

    logic m_xfer, s_xfer, last, abort_op, cmd_ok;

    assign m_xfer   = mvalid_q & bus.m_ready;
    assign s_xfer   = sready_q & bus.s_valid;
    assign last     = (cnt_q == LAST);
    // FIN is the closing cycle; abort only acts on a running transfer.
    assign cmd_ok   = (state_q == IDLE) || (state_q == FIN);
    assign abort_op = abort & ~cmd_ok;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_n;
    end

    always_comb begin
        state_n = state_q;
        if (abort_op) begin
            state_n = IDLE;
        end else begin
            unique case (state_q)
                IDLE, FIN: begin
                    state_n = IDLE;
                    if (start) state_n = dir ? R_IN : S_ADDR;
                end
                S_ADDR: state_n = S_WAIT;
                S_WAIT: if (w_q == 3'd0) state_n = S_OUT;
                S_OUT:  if (m_xfer) state_n = last ? S_LAST : S_ADDR;
                R_IN:   if (s_xfer) state_n = R_WR;
                R_WR:   state_n = last ? R_LAST : R_IN;
`ifdef SST_SEQ_CRC_EN
                S_CRC:  if (m_xfer) state_n = FIN;
                R_CRC:  if (s_xfer) state_n = FIN;
`endif
                default: state_n = IDLE;
            endcase
        end
    end

    always_comb begin
        cnt_d    = cnt_q;
        w_d      = w_q;
        act_d    = act_q;
        addr_d   = addr_q;
        we_d     = 1'b0;
        dato_d   = dato_q;
        mvalid_d = mvalid_q;
        mdata_d  = mdata_q;
        sready_d = sready_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        err_d    = err_q;
`ifdef SST_SEQ_CRC_EN
        crc_d    = crc_q;
`endif
        if (!abort_op) begin
            unique case (state_q)
                IDLE, FIN: begin
                    if (start) begin
                        busy_d   = 1'b1;
                        err_d    = 1'b0;
                        act_d    = 1'b1;
                        addr_d   = 8'd0;
                        cnt_d    = 8'd0;
                        sready_d = dir;
`ifdef SST_SEQ_CRC_EN
                        crc_d    = 8'd0;
`endif
                    end
                end
                S_ADDR: w_d = W0;
                S_WAIT: begin
                    if (w_q == 3'd0) begin
                        mdata_d  = bus.sst_di;
                        mvalid_d = 1'b1;
                    end else begin
                        w_d = w_q - 3'd1;
                    end
                end
                S_OUT: begin
                    if (m_xfer) begin
                        mvalid_d = 1'b0;
`ifdef SST_SEQ_CRC_EN
                        crc_d = crc8(crc_q, mdata_q);
`endif
                        if (!last) begin
                            cnt_d  = cnt_q + 8'd1;
                            addr_d = addr_q + 8'd1;
                        end
`ifdef SST_SEQ_CRC_EN
                        else begin
                            // Trailer goes out with the same handshake.
                            mdata_d  = crc8(crc_q, mdata_q);
                            mvalid_d = 1'b1;
                        end
`endif
                    end
                end
                R_IN: begin
                    if (s_xfer) begin
                        dato_d   = bus.s_data;
                        sready_d = 1'b0;
                        we_d     = 1'b1;
                        // Foreign index byte flags an error but is
                        // still written.
                        if (cnt_q == IDX && bus.s_data != map_idx)
                            err_d = 1'b1;
`ifdef SST_SEQ_CRC_EN
                        crc_d = crc8(crc_q, bus.s_data);
`endif
                    end
                end
                R_WR: begin
                    if (!last) begin
                        cnt_d    = cnt_q + 8'd1;
                        addr_d   = addr_q + 8'd1;
                        sready_d = 1'b1;
                    end
`ifdef SST_SEQ_CRC_EN
                    else begin
                        sready_d = 1'b1;
                    end
`endif
                end
`ifdef SST_SEQ_CRC_EN
                S_CRC: if (m_xfer) mvalid_d = 1'b0;
                R_CRC: begin
                    if (s_xfer) begin
                        sready_d = 1'b0;
                        if (bus.s_data != crc_q) err_d = 1'b1;
                    end
                end
`endif
                default: ;
            endcase
            if (state_n == FIN) begin
                act_d  = 1'b0;
                busy_d = 1'b0;
                done_d = 1'b1;
                addr_d = 8'd0;
                cnt_d  = 8'd0;
            end
        end else begin
            act_d    = 1'b0;
            we_d     = 1'b0;
            mvalid_d = 1'b0;
            sready_d = 1'b0;
            busy_d   = 1'b0;
            err_d    = 1'b1;
            done_d   = 1'b1;
            addr_d   = 8'd0;
            cnt_d    = 8'd0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q    <= 8'd0;
            w_q      <= 3'd0;
            act_q    <= 1'b0;
            addr_q   <= 8'd0;
            we_q     <= 1'b0;
            dato_q   <= 8'd0;
            mvalid_q <= 1'b0;
            mdata_q  <= 8'd0;
            sready_q <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
`ifdef SST_SEQ_CRC_EN
            crc_q    <= 8'd0;
`endif
        end else begin
            cnt_q    <= cnt_d;
            w_q      <= w_d;
            act_q    <= act_d;
            addr_q   <= addr_d;
            we_q     <= we_d;
            dato_q   <= dato_d;
            mvalid_q <= mvalid_d;
            mdata_q  <= mdata_d;
            sready_q <= sready_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            err_q    <= err_d;
`ifdef SST_SEQ_CRC_EN
            crc_q    <= crc_d;
`endif
        end
    end

    assign bus.sst_act    = act_q;
    assign bus.sst_addr   = addr_q;
    assign bus.sst_we_reg = we_q;
    assign bus.sst_dato   = dato_q;
    assign bus.m_valid    = mvalid_q;
    assign bus.m_data     = mdata_q;
    assign bus.s_ready    = sready_q;
    assign busy           = busy_q;
    assign done           = done_q;
    assign err            = err_q;

endmodule
